md_rx_arbiter: RTL and testbench

MD_RX_ARBITER -- requirements
Module: md_rx_arbiter

---
 rtl/md_rx_arbiter.sv | 133 +++++++++++++
 tb/tb_md_rx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_rx_arbiter.sv
// rtl/md_rx_arbiter.sv - packet-granular two-port round-robin arbiter feeding the FAST RX path
module md_rx_arbiter #(
    parameter int DATA_W = 256,
    parameter int KEEP_W = 32,
    parameter int USER_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic [KEEP_W-1:0] s0_axis_tkeep,
    input  logic [USER_W-1:0] s0_axis_tuser,
    input  logic              s0_axis_tvalid,
    input  logic              s0_axis_tlast,
    output logic              s0_axis_tready,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic [KEEP_W-1:0] s1_axis_tkeep,
    input  logic [USER_W-1:0] s1_axis_tuser,
    input  logic              s1_axis_tvalid,
    input  logic              s1_axis_tlast,
    output logic              s1_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic [USER_W-1:0] m_axis_tuser,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [31:0]       pkt_cnt0,
    output logic [31:0]       pkt_cnt1,
    output logic [1:0]        cur_grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   rr_ptr, rr_ptr_nxt;
    logic   out_free;
    logic   acc0, acc1;

    assign out_free = !m_axis_tvalid || m_axis_tready;
    assign acc0     = s0_axis_tvalid && s0_axis_tready;
    assign acc1     = s1_axis_tvalid && s1_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // The grant is held until the owning port's tlast beat is accepted.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (s0_axis_tvalid && s1_axis_tvalid)
                    state_nxt = rr_ptr ? GRANT1 : GRANT0;
                else if (s0_axis_tvalid)
                    state_nxt = GRANT0;
                else if (s1_axis_tvalid)
                    state_nxt = GRANT1;
            end
            GRANT0: begin
                if (acc0 && s0_axis_tlast) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = 1'b1;
                end
            end
            GRANT1: begin
                if (acc1 && s1_axis_tlast) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is gated by rst so the inputs stall even before the state register clears.
    always_comb begin
        s0_axis_tready = !rst && (state == GRANT0) && out_free;
        s1_axis_tready = !rst && (state == GRANT1) && out_free;
        cur_grant      = 2'b00;
        if (state == GRANT0)
            cur_grant = 2'b01;
        else if (state == GRANT1)
            cur_grant = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
        end else if (acc0) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= s0_axis_tlast;
            m_axis_tdata  <= s0_axis_tdata;
            m_axis_tkeep  <= s0_axis_tkeep;
            m_axis_tuser  <= s0_axis_tuser;
        end else if (acc1) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= s1_axis_tlast;
            m_axis_tdata  <= s1_axis_tdata;
            m_axis_tkeep  <= s1_axis_tkeep;
            m_axis_tuser  <= s1_axis_tuser;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt0 <= 32'd0;
            pkt_cnt1 <= 32'd0;
        end else begin
            if (acc0 && s0_axis_tlast)
                pkt_cnt0 <= pkt_cnt0 + 32'd1;
            if (acc1 && s1_axis_tlast)
                pkt_cnt1 <= pkt_cnt1 + 32'd1;
        end
    end

endmodule

// File: tb/tb_md_rx_arbiter.sv
// tb/tb_md_rx_arbiter.sv - directed scoreboard bench for md_rx_arbiter
module tb_md_rx_arbiter;

    localparam int DATA_W = 256;
    localparam int KEEP_W = 32;
    localparam int USER_W = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
    logic [KEEP_W-1:0] s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
    logic [USER_W-1:0] s0_axis_tuser, s1_axis_tuser, m_axis_tuser;
    logic              s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
    logic              s0_axis_tlast, s1_axis_tlast, m_axis_tlast;
    logic              s0_axis_tready, s1_axis_tready, m_axis_tready;
    logic [31:0]       pkt_cnt0, pkt_cnt1;
    logic [1:0]        cur_grant;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [KEEP_W-1:0] k;
        logic [USER_W-1:0] u;
        logic              l;
    } beat_t;

    beat_t sb[$];

    md_rx_arbiter #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W)) dut (
        .clk(clk), .rst(rst),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tuser(s0_axis_tuser),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tuser(s1_axis_tuser),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .cur_grant(cur_grant)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_word(input int p, input int k, input int b);
        logic [7:0] pp, kk, bb;
        pp = p[7:0];
        kk = k[7:0];
        bb = b[7:0];
        return {pp, kk, bb, 8'h5A};
    endfunction

    function automatic beat_t mk_beat(input int p, input int k, input int b, input int nb);
        beat_t e;
        logic [31:0] w;
        w   = mk_word(p, k, b);
        e.d = {8{w}};
        e.k = {w[15:8], w[23:16], w[31:24], 8'hC3};
        e.u = {4{w ^ 32'h1234_5678}};
        e.l = (b == nb - 1);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 1) ? s1_axis_tready : s0_axis_tready;
    endfunction

    task automatic drive(input int p, input logic v, input int k, input int b, input int nb);
        beat_t e;
        e = mk_beat(p, k, b, nb);
        if (p == 0) begin
            s0_axis_tvalid = v; s0_axis_tdata = e.d; s0_axis_tkeep = e.k;
            s0_axis_tuser = e.u; s0_axis_tlast = v && e.l;
        end else begin
            s1_axis_tvalid = v; s1_axis_tdata = e.d; s1_axis_tkeep = e.k;
            s1_axis_tuser = e.u; s1_axis_tlast = v && e.l;
        end
    endtask

    task automatic push_pkt(input int p, input int k, input int nb);
        for (int b = 0; b < nb; b++)
            sb.push_back(mk_beat(p, k, b, nb));
    endtask

    // Called at posedge+1; returns at posedge+1 after the last beat is accepted.
    task automatic send_pkt(input int p, input int k, input int nb, input int gap_at, input int gap);
        int t;
        for (int b = 0; b < nb; b++) begin
            if (b == gap_at) begin
                drive(p, 1'b0, k, b, nb);
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk("gap_grant", cur_grant, (p == 1) ? 2'b10 : 2'b01);
                    chk("gap_other_ready", rdy(1 - p), 1'b0);
                    @(posedge clk); #1;
                end
            end
            drive(p, 1'b1, k, b, nb);
            t = 0;
            @(negedge clk);
            while (!rdy(p) && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("handshake_p%0d_b%0d", p, b), rdy(p), 1'b1);
            @(posedge clk); #1;
        end
        drive(p, 1'b0, k, 0, nb);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            chk("sb_nonempty", (sb.size() > 0), 1'b1);
            if (sb.size() > 0) begin
                beat_t e;
                e = sb.pop_front();
                chk("m_tdata", m_axis_tdata, e.d);
                chk("m_tkeep", m_axis_tkeep, e.k);
                chk("m_tuser", m_axis_tuser, e.u);
                chk("m_tlast", m_axis_tlast, e.l);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m_axis_tready = 1'b1;
        drive(0, 1'b0, 0, 0, 1);
        drive(1, 1'b0, 0, 0, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_tdata", m_axis_tdata, '0);
        chk("rst_cnt0", pkt_cnt0, 32'd0);
        chk("rst_cnt1", pkt_cnt1, 32'd0);
        chk("rst_grant", cur_grant, 2'b00);
        chk("rst_rr", dut.rr_ptr, 1'b0);
        @(posedge clk); #1;

        // Port 0 alone, 4 beats, latency and full rate.
        push_pkt(0, 1, 4);
        fork
            send_pkt(0, 1, 4, -1, 0);
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                chk($sformatf("lat_tvalid_c%0d", c), m_axis_tvalid, (c >= 2));
                if (c == 1) chk("lat_grant", cur_grant, 2'b01);
                if (c == 5) chk("lat_tlast", m_axis_tlast, 1'b1);
            end
        join
        drain();
        chk("a_cnt0", pkt_cnt0, 32'd1);

        // Reset on beat 2 of a 4-beat packet: only beats 0 and 1 ever emerge.
        sb.push_back(mk_beat(0, 2, 0, 4));
        sb.push_back(mk_beat(0, 2, 1, 4));
        drive(0, 1'b1, 2, 0, 4);
        @(posedge clk);
        @(posedge clk); #1 drive(0, 1'b1, 2, 1, 4);
        @(posedge clk); #1 drive(0, 1'b1, 2, 2, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_s0_ready", s0_axis_tready, 1'b0);
        chk("rst_s1_ready", s1_axis_tready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 2, 0, 4);
        @(negedge clk);
        chk("b_tvalid", m_axis_tvalid, 1'b0);
        chk("b_cnt0", pkt_cnt0, 32'd0);
        chk("b_grant", cur_grant, 2'b00);
        chk("b_sb_empty", sb.size(), 0);
        repeat (3) begin
            @(negedge clk);
            chk("b_no_stale", m_axis_tvalid, 1'b0);
        end
        @(posedge clk); #1;
        push_pkt(1, 3, 2);
        send_pkt(1, 3, 2, -1, 0);
        drain();
        chk("b_cnt1", pkt_cnt1, 32'd1);

        // Both ports from reset: port 0, bubble, port 1.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push_pkt(0, 4, 3);
        push_pkt(1, 5, 3);
        fork
            send_pkt(0, 4, 3, -1, 0);
            send_pkt(1, 5, 3, -1, 0);
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                chk($sformatf("rr_tvalid_c%0d", c), m_axis_tvalid,
                    (c >= 2 && c <= 4) || (c >= 6 && c <= 8));
                chk($sformatf("rr_grant_c%0d", c), cur_grant,
                    (c >= 1 && c <= 3) ? 2'b01 : (c >= 5 && c <= 7) ? 2'b10 : 2'b00);
            end
        join
        @(posedge clk); #1;
        drain();
        chk("c_cnt0", pkt_cnt0, 32'd1);
        chk("c_cnt1", pkt_cnt1, 32'd1);
        chk("c_rr", dut.rr_ptr, 1'b0);

        // Downstream stall of 5 cycles mid-packet.
        push_pkt(0, 6, 4);
        fork
            send_pkt(0, 6, 4, -1, 0);
            begin
                repeat (3) @(posedge clk);
                #1 m_axis_tready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_tvalid", m_axis_tvalid, 1'b1);
                    chk("stall_tdata", m_axis_tdata, sb[0].d);
                    chk("stall_tuser", m_axis_tuser, sb[0].u);
                    chk("stall_s0_ready", s0_axis_tready, 1'b0);
                end
                @(posedge clk); #1 m_axis_tready = 1'b1;
            end
        join
        drain();
        chk("d_cnt0", pkt_cnt0, 32'd2);

        // Port 1 drops tvalid for 3 cycles mid-packet while port 0 waits.
        push_pkt(1, 7, 5);
        push_pkt(0, 8, 2);
        fork
            send_pkt(1, 7, 5, 2, 3);
            begin
                repeat (2) @(posedge clk);
                #1 send_pkt(0, 8, 2, -1, 0);
            end
        join
        drain();
        chk("e_cnt0", pkt_cnt0, 32'd3);
        chk("e_cnt1", pkt_cnt1, 32'd2);

        // Counter wrap with a single-beat packet.
        @(negedge clk);
        force dut.pkt_cnt0 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.pkt_cnt0;
        push_pkt(0, 9, 1);
        send_pkt(0, 9, 1, -1, 0);
        drain();
        @(negedge clk);
        chk("f_cnt0_wrap", pkt_cnt0, 32'd0);
        chk("f_grant_idle", cur_grant, 2'b00);
        chk("f_cnt1", pkt_cnt1, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
